// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and channel state type for the button debouncer
package btn_pkg;

    localparam int NUM_BTN_DEFAULT = 4;
    localparam int DEBOUNCE_SIM    = 4;
    localparam int DEBOUNCE_HW     = 100_000;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } ch_state_t;

endpackage

// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - raw button pins and conditioned button outputs
interface btn_debounce_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_db;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] btn_fall;
    logic [NUM_BTN-1:0] btn_tgl;

    modport master (
        output btn_raw,
        input  btn_db,
        input  btn_rise,
        input  btn_fall,
        input  btn_tgl
    );

    modport slave (
        input  btn_raw,
        output btn_db,
        output btn_rise,
        output btn_fall,
        output btn_tgl
    );
endinterface

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one button channel: 2-flop synchroniser, stability counter,
// debounced level, registered edge pulses and press toggle
module debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_HW
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_tgl
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic          stable, stable_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rise_n, fall_n, tgl_n;
    ch_state_t     st, st_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            cnt      <= '0;
            st       <= IDLE;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            btn_tgl  <= 1'b0;
        end else begin
            s1       <= btn_raw;
            s2       <= s1;
            stable   <= stable_n;
            cnt      <= cnt_n;
            st       <= st_n;
            btn_rise <= rise_n;
            btn_fall <= fall_n;
            btn_tgl  <= tgl_n;
        end
    end

    always_comb begin
        st_n     = st;
        cnt_n    = cnt;
        stable_n = stable;
        rise_n   = 1'b0;
        fall_n   = 1'b0;
        tgl_n    = btn_tgl;
        case (st)
            IDLE: begin
                cnt_n = '0;
                if (s2 != stable) begin
                    st_n  = COUNTING;
                    cnt_n = CW'(1);
                end
            end
            COUNTING: begin
                if (s2 == stable) begin
                    // glitch: drop the partial count and wait for the next mismatch
                    st_n  = IDLE;
                    cnt_n = '0;
                end else if (cnt == TERM) begin
                    st_n     = IDLE;
                    cnt_n    = '0;
                    stable_n = s2;
                    rise_n   = s2;
                    fall_n   = ~s2;
                    tgl_n    = btn_tgl ^ s2;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                st_n  = IDLE;
                cnt_n = '0;
            end
        endcase
    end

    assign btn_db = stable;

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - NUM_BTN independent debounce channels behind one interface
module btn_debounce
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_HW
) (
    input  logic           clk,
    input  logic           rst,
    btn_debounce_if.slave  bif
);

    logic [NUM_BTN-1:0] db_v, rise_v, fall_v, tgl_v;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .btn_raw  (bif.btn_raw[i]),
            .btn_db   (db_v[i]),
            .btn_rise (rise_v[i]),
            .btn_fall (fall_v[i]),
            .btn_tgl  (tgl_v[i])
        );
    end

    assign bif.btn_db   = db_v;
    assign bif.btn_rise = rise_v;
    assign bif.btn_fall = fall_v;
    assign bif.btn_tgl  = tgl_v;

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Conditions the raw push-button inputs of the board before they reach the LED group-blanking logic. Each button is synchronised to the system clock, debounced by a per-channel stability counter, and presented three ways: a clean level (`btn_db`), single-cycle edge pulses (`btn_rise`, `btn_fall`), and a press-toggled latch (`btn_tgl`). `btn_db` or `btn_tgl` drives the 4-bit `btn` input of the switch/LED group stage directly.

## Interface
- `NUM_BTN`, default 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 100_000: number of consecutive clock cycles of stable synchronised input required to accept a change. Minimum 2. At 100 MHz, 100_000 gives 1 ms.
- `clk`, input, 1: system clock. All state changes occur on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `btn_raw`, input, NUM_BTN: raw button pins. Asynchronous and bouncing.
- `btn_db`, output, NUM_BTN: debounced level.
- `btn_rise`, output, NUM_BTN: one-cycle pulse when `btn_db` goes 0→1.
- `btn_fall`, output, NUM_BTN: one-cycle pulse when `btn_db` goes 1→0.
- `btn_tgl`, output, NUM_BTN: latch that inverts on each accepted press.

Reset and clocking are fixed for this block: one clock; reset is asynchronous and active-high.

## Operation
- Channels are fully independent. There is no cross-channel interaction.
- **Synchroniser:** two flip-flops per channel, `s1 <= btn_raw` and `s2 <= s1`. Only `s2` is used downstream.
- **Stable register:** `stable`, which drives `btn_db`.
- **Counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
- Per channel, on each clock edge:
  - **`s2 == stable`:** `cnt <= 0`. No output change.
  - **`s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`:** `cnt <= cnt+1`.
  - **`s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`:** `stable <= s2` and `cnt <= 0`.
    - If `s2` is 1: `btn_rise` is 1 and `btn_tgl` inverts on this edge.
    - If `s2` is 0: `btn_fall` is 1.
- Any glitch that returns `s2` to `stable` before the terminal count clears `cnt`. Counting restarts from 0 on the next mismatch.
- `btn_rise` and `btn_fall` are registered and high for exactly one cycle. They are never high together on the same channel.
- **States per channel:** IDLE (`cnt==0`, match) and COUNTING (mismatch). Transitions:
  - COUNTING→IDLE on a glitch, with no output change.
  - COUNTING→IDLE on terminal count, with an output update.
- **Reset** (any time, including mid-count): `s1`, `s2`, `stable`, `cnt`, `btn_db`, `btn_rise`, `btn_fall` and `btn_tgl` all go to 0 immediately.
  - A button held through reset is accepted as a new press `DEBOUNCE_CYCLES+2` edges after reset release.
- **Counter width:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.

## Timing
- Let `btn_raw` change before edge k and then hold. Then:
  - `s1` updates at edge k.
  - `s2` updates at edge k+1.
  - `btn_db` updates at edge k+1+DEBOUNCE_CYCLES.
- Total latency is `DEBOUNCE_CYCLES+2` cycles.
- `btn_rise` / `btn_fall` rise on the same edge as `btn_db` and fall one edge later.
- `btn_tgl` updates on the same edge as `btn_rise`.
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` cycles as seen at `s2`.
  - A raw pulse of `DEBOUNCE_CYCLES-1` cycles is rejected.
- No combinational path exists from `btn_raw` to any output.

## Structure
- Shared package `btn_pkg`:
  - `NUM_BTN_DEFAULT = 4`.
  - `DEBOUNCE_SIM = 4` for benches.
  - `DEBOUNCE_HW = 100_000`.
- Sub-module `debounce_ch`: a single channel containing the synchroniser, counter, `stable`, edge pulses and toggle.
  - `btn_debounce` instantiates `NUM_BTN` copies in a generate loop and concatenates the outputs.
- `debounce_ch` is verified alone, then the top is verified as a whole.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, clock period 10 ns.
- **Clean press and release.** Set `btn_raw[0]` 0→1 before edge k and hold for 20 cycles, then release.
  - `btn_db[0]`=1 at edge k+5.
  - `btn_rise[0]` high only for the cycle after edge k+5.
  - `btn_tgl[0]` 0→1.
  - On release: `btn_db[0]`=0 and a `btn_fall[0]` pulse 5 edges later, with `btn_tgl[0]` unchanged.
- **Bounce rejection.** Drive `btn_raw[1]` with the pattern 1,0,1,0,1 (one cycle each), then hold 1.
  - Exactly one `btn_rise[1]` pulse, 5 edges after the final 0→1.
  - No pulse during the bounce.
- **Short pulse.** Drive `btn_raw[2]` high for 3 cycles, then 0.
  - `btn_db[2]` stays 0 and no pulses occur.
- **Toggle sequence and independence.** Give `btn_raw[3]` three clean presses while `btn_raw[2:0]` are held constant.
  - `btn_tgl[3]` sequence 1,0,1.
  - Other channels' outputs unchanged.
- **Reset mid-count and held through reset.**
  - Assert `rst` two cycles into a count: all outputs go to 0 immediately.
  - With `btn_raw[0]` held 1 through reset release, `btn_db[0]`=1 and `btn_rise[0]` pulse 6 edges after release.
- **Simultaneous presses.** Drive `btn_raw` 0000→0101 on one edge.
  - `btn_rise` = 0101 for one cycle.
  - `btn_db` = 0101.
  - Downstream group 0 and group 2 LEDs blank.
